// File: rtl/simple_cnt_obi_sbr.sv
// simple_cnt_obi_sbr: OBI subordinate exposing a prescaled up-counter with
// compare/wrap, a sticky W1C match flag and an optional level interrupt.
// Build option: define SIMPLE_CNT_IRQ_EN to implement CTRL.irq_en and irq_o;
// without it CTRL[1] reads 0, ignores writes, and irq_o is tied 0.
// Register map (addr[4:2]): 0 CTRL, 1 VALUE, 2 CMP, 3 PRESC, 4 STATUS, 5..7 unmapped.
module simple_cnt_obi_sbr #(
  parameter int unsigned CntWidth   = 32,
  parameter int unsigned PrescWidth = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [73:0] obi_req_i,
  output logic [38:0] obi_rsp_o,
  output logic        irq_o
);

`ifdef SIMPLE_CNT_IRQ_EN
  localparam logic [2:0] CtrlMask = 3'b111;
`else
  localparam logic [2:0] CtrlMask = 3'b101;
`endif

  // Request fields, packed {addr, we, be, wdata, aid, a_optional, req}
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [2:0]  aid;
  logic [2:0]  sel;
  logic        unused;

  assign req    = obi_req_i[0];
  assign aid    = obi_req_i[4:2];
  assign wdata  = obi_req_i[36:5];
  assign be     = obi_req_i[40:37];
  assign we     = obi_req_i[41];
  assign sel    = obi_req_i[46:44];
  assign unused = ^{obi_req_i[73:47], obi_req_i[43:42], obi_req_i[1]};

  // Architectural state
  logic [2:0]            ctrl_reg, ctrl_next;
  logic [CntWidth-1:0]   value_reg, value_next;
  logic [CntWidth-1:0]   cmp_reg, cmp_next;
  logic [PrescWidth-1:0] presc_reg, presc_next;
  logic [PrescWidth-1:0] pcnt_reg, pcnt_next;
  logic                  match_reg, match_next;

  // Response pipeline
  logic        rvalid_reg;
  logic [2:0]  rid_reg;
  logic        err_reg, err_next;
  logic [31:0] rdata_reg, rdata_next;

  logic wr, mapped, wr_ctrl, wr_value, wr_cmp, wr_presc, wr_status;
  logic tick, hit;
  logic [31:0] merged_value, merged_cmp, merged_presc;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be_v);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be_v[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

  assign wr        = req & we;
  assign mapped    = (sel <= 3'd4);
  assign wr_ctrl   = wr && (sel == 3'd0);
  assign wr_value  = wr && (sel == 3'd1);
  assign wr_cmp    = wr && (sel == 3'd2);
  assign wr_presc  = wr && (sel == 3'd3);
  assign wr_status = wr && (sel == 3'd4);

  // A tick that collides with a bus write to VALUE is dropped entirely
  assign tick = ctrl_reg[0] && (pcnt_reg == presc_reg);
  assign hit  = tick && !wr_value && (value_reg == cmp_reg);

  assign merged_value = byte_merge(32'(value_reg), wdata, be);
  assign merged_cmp   = byte_merge(32'(cmp_reg), wdata, be);
  assign merged_presc = byte_merge(32'(presc_reg), wdata, be);

  // Next-state for registers, prescaler and read response
  always_comb begin
    ctrl_next  = ctrl_reg;
    value_next = value_reg;
    cmp_next   = cmp_reg;
    presc_next = presc_reg;
    pcnt_next  = pcnt_reg;
    match_next = match_reg;
    rdata_next = 32'h0;
    err_next   = 1'b0;

    // Oneshot auto-disable first, so a same-cycle bus write to en wins
    if (hit && ctrl_reg[2]) ctrl_next[0] = 1'b0;
    if (wr_ctrl && be[0]) ctrl_next = wdata[2:0] & CtrlMask;

    if (wr_value)  value_next = merged_value[CntWidth-1:0];
    else if (tick) value_next = (value_reg == cmp_reg) ? '0 : value_reg + CntWidth'(1);

    if (wr_cmp)   cmp_next   = merged_cmp[CntWidth-1:0];
    if (wr_presc) presc_next = merged_presc[PrescWidth-1:0];

    if (!ctrl_reg[0] || wr_presc || tick) pcnt_next = '0;
    else                                  pcnt_next = pcnt_reg + PrescWidth'(1);

    // Match set has priority over the W1C clear
    if (hit)                                      match_next = 1'b1;
    else if (wr_status && be[0] && wdata[0])      match_next = 1'b0;

    if (req) begin
      err_next = !mapped;
      if (!we) begin
        case (sel)
          3'd0:    rdata_next = {29'h0, ctrl_reg};
          3'd1:    rdata_next = 32'(value_reg);
          3'd2:    rdata_next = 32'(cmp_reg);
          3'd3:    rdata_next = 32'(presc_reg);
          3'd4:    rdata_next = {31'h0, match_reg};
          default: rdata_next = 32'h0;
        endcase
      end
    end
  end

  // State and response registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_reg   <= '0;
      value_reg  <= '0;
      cmp_reg    <= '0;
      presc_reg  <= '0;
      pcnt_reg   <= '0;
      match_reg  <= 1'b0;
      rvalid_reg <= 1'b0;
      rid_reg    <= '0;
      err_reg    <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      ctrl_reg   <= ctrl_next;
      value_reg  <= value_next;
      cmp_reg    <= cmp_next;
      presc_reg  <= presc_next;
      pcnt_reg   <= pcnt_next;
      match_reg  <= match_next;
      rvalid_reg <= req;
      rid_reg    <= aid;
      err_reg    <= err_next;
      rdata_reg  <= rdata_next;
    end
  end

  // Response: a response pending when reset arrives is suppressed immediately
  logic rvalid_out;
  assign rvalid_out = rvalid_reg & ~rst_i;
  assign obi_rsp_o  = {rvalid_out ? rdata_reg : 32'h0,
                       rvalid_out ? rid_reg : 3'h0,
                       rvalid_out & err_reg,
                       1'b0,
                       req,
                       rvalid_out};

`ifdef SIMPLE_CNT_IRQ_EN
  logic irq_reg;
  // Interrupt follows the registered flag state one cycle later
  always_ff @(posedge clk_i) begin
    if (rst_i) irq_reg <= 1'b0;
    else       irq_reg <= match_reg & ctrl_reg[1];
  end
  assign irq_o = irq_reg;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_simple_cnt_obi_sbr.sv
// Directed testbench for simple_cnt_obi_sbr: drives back-to-back OBI
// sequences and checks responses against hand-computed values.
module tb_simple_cnt_obi_sbr;

`ifdef SIMPLE_CNT_IRQ_EN
  localparam logic IRQ_IMPL = 1'b1;
`else
  localparam logic IRQ_IMPL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [73:0] obi_req;
  logic [38:0] obi_rsp;
  logic        irq;

  logic        req_v, we_v;
  logic [31:0] addr_v, wdata_v;
  logic [3:0]  be_v;
  logic [2:0]  aid_v;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign obi_req = {addr_v, we_v, be_v, wdata_v, aid_v, 1'b0, req_v};

  logic        rvalid, gnt, err;
  logic [2:0]  rid;
  logic [31:0] rdata;
  assign rvalid = obi_rsp[0];
  assign gnt    = obi_rsp[1];
  assign err    = obi_rsp[3];
  assign rid    = obi_rsp[6:4];
  assign rdata  = obi_rsp[38:7];

  simple_cnt_obi_sbr dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .obi_req_i (obi_req),
    .obi_rsp_o (obi_rsp),
    .irq_o     (irq)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } txn_t;

  txn_t        seq[$];
  logic [31:0] rd_q[$];
  logic        er_q[$];
  logic [2:0]  ri_q[$];
  logic        rv_q[$];
  logic        gn_q[$];
  logic        irq_q[$];

  task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata; t.be = be;
    seq.push_back(t);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
    add(1'b1, addr, wdata, 4'hF);
  endtask

  task automatic rd(input logic [31:0] addr);
    add(1'b0, addr, 32'h0, 4'h0);
  endtask

  // Issue the queued transactions on consecutive cycles, capturing each response
  task automatic run_seq();
    int n;
    n = seq.size();
    rd_q.delete(); er_q.delete(); ri_q.delete();
    rv_q.delete(); gn_q.delete(); irq_q.delete();
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      irq_q.push_back(irq);
      if (i > 0) begin
        rv_q.push_back(rvalid);
        rd_q.push_back(rdata);
        er_q.push_back(err);
        ri_q.push_back(rid);
        $display("txn we=%0b addr=%h wdata=%h be=%b -> rvalid=%0b rdata=%h err=%0b rid=%0d",
                 seq[i-1].we, seq[i-1].addr, seq[i-1].wdata, seq[i-1].be,
                 rvalid, rdata, err, rid);
      end
      if (i < n) begin
        req_v = 1'b1; we_v = seq[i].we; addr_v = seq[i].addr;
        wdata_v = seq[i].wdata; be_v = seq[i].be;
        #1;
        gn_q.push_back(gnt);
      end else begin
        req_v = 1'b0; we_v = 1'b0; be_v = 4'h0;
      end
    end
    seq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_v = 1'b0; we_v = 1'b0; addr_v = '0; wdata_v = '0; be_v = '0; aid_v = 3'b101;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obi_rsp !== 39'h0) begin n_bad++; $display("FAIL reset_rsp got %h expected 0", obi_rsp); end
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got %b expected 0", irq); end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back_reads();
    logic [31:0] addrs [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    foreach (addrs[k]) rd(addrs[k]);
    run_seq();
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (rd_q[k] !== 32'h0 || er_q[k] !== 1'b0) begin
        n_bad++; $display("FAIL reset_val[%0d] got %h/%b expected 0/0", k, rd_q[k], er_q[k]);
      end
      n_cmp++;
      if (rv_q[k] !== 1'b1 || gn_q[k] !== 1'b1) begin
        n_bad++; $display("FAIL handshake[%0d] got rvalid=%b gnt=%b expected 1/1", k, rv_q[k], gn_q[k]);
      end
      n_cmp++;
      if (ri_q[k] !== 3'b101) begin
        n_bad++; $display("FAIL rid[%0d] got %b expected 101", k, ri_q[k]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (rvalid !== 1'b0) begin n_bad++; $display("FAIL rvalid_idle got %b expected 0", rvalid); end
  endtask

  task automatic test_count_wrap();
    int          idx [8] = '{3, 4, 5, 6, 7, 8, 11, 12};
    logic [31:0] ex  [8] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1, 32'd0, 32'd3};
    wr(32'h8, 32'd3); wr(32'hC, 32'd0); wr(32'h0, 32'h3);
    repeat (5) rd(32'h4);
    rd(32'h10); wr(32'h0, 32'h2); wr(32'h10, 32'h1); rd(32'h10); rd(32'h4);
    run_seq();
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (rd_q[idx[k]] !== ex[k]) begin
        n_bad++; $display("FAIL wrap_read[%0d] got %h expected %h", idx[k], rd_q[idx[k]], ex[k]);
      end
    end
    n_cmp++;
    if (irq_q[7] !== 1'b0) begin n_bad++; $display("FAIL irq_at_match got %b expected 0", irq_q[7]); end
    n_cmp++;
    if (irq_q[8] !== IRQ_IMPL) begin n_bad++; $display("FAIL irq_after_match got %b expected %b", irq_q[8], IRQ_IMPL); end
    n_cmp++;
    if (irq_q[11] !== IRQ_IMPL) begin n_bad++; $display("FAIL irq_before_clear got %b expected %b", irq_q[11], IRQ_IMPL); end
    n_cmp++;
    if (irq_q[12] !== 1'b0) begin n_bad++; $display("FAIL irq_after_clear got %b expected 0", irq_q[12]); end
  endtask

  task automatic test_oneshot();
    logic [31:0] ex [10] = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd0, 32'h4, 32'h1, 32'd0};
    wr(32'h0, 32'h0); wr(32'h4, 32'h0); wr(32'hC, 32'd2); wr(32'h8, 32'd1); wr(32'h0, 32'h5);
    repeat (7) rd(32'h4);
    rd(32'h0); rd(32'h10); rd(32'h4); wr(32'h10, 32'h1);
    run_seq();
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (rd_q[k+5] !== ex[k]) begin
        n_bad++; $display("FAIL oneshot_read[%0d] got %h expected %h", k + 5, rd_q[k+5], ex[k]);
      end
    end
  endtask

  task automatic test_value_wrap_collision();
    int          idx [5] = '{5, 6, 7, 9, 11};
    logic [31:0] ex  [5] = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'h55, 32'h57};
    wr(32'h0, 32'h0); wr(32'hC, 32'h0); wr(32'h8, 32'h10); wr(32'h4, 32'hFFFF_FFFF); wr(32'h0, 32'h1);
    rd(32'h4); rd(32'h4); rd(32'h10); wr(32'h4, 32'h55); rd(32'h4); wr(32'h0, 32'h0); rd(32'h4);
    run_seq();
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (rd_q[idx[k]] !== ex[k]) begin
        n_bad++; $display("FAIL vwrap_read[%0d] got %h expected %h", idx[k], rd_q[idx[k]], ex[k]);
      end
    end
  endtask

  task automatic test_byte_write();
    wr(32'h4, 32'h0); add(1'b1, 32'h4, 32'hAABB_CCDD, 4'b0010); rd(32'h4);
    wr(32'h8, 32'h0); add(1'b1, 32'h8, 32'h1122_3344, 4'b1001); rd(32'h8);
    run_seq();
    n_cmp++;
    if (rd_q[2] !== 32'h0000_CC00) begin n_bad++; $display("FAIL byte_value got %h expected 0000cc00", rd_q[2]); end
    n_cmp++;
    if (rd_q[5] !== 32'h1100_0044) begin n_bad++; $display("FAIL byte_cmp got %h expected 11000044", rd_q[5]); end
  endtask

  task automatic test_unmapped();
    wr(32'h4, 32'h77); wr(32'h1C, 32'hFFFF_FFFF); rd(32'h18); rd(32'h14); rd(32'h4); rd(32'h24);
    run_seq();
    n_cmp++;
    if (er_q[1] !== 1'b1) begin n_bad++; $display("FAIL unmapped_wr_err got %b expected 1", er_q[1]); end
    n_cmp++;
    if (er_q[2] !== 1'b1 || rd_q[2] !== 32'h0) begin
      n_bad++; $display("FAIL unmapped_rd_18 got err=%b rdata=%h expected 1/0", er_q[2], rd_q[2]);
    end
    n_cmp++;
    if (er_q[3] !== 1'b1) begin n_bad++; $display("FAIL unmapped_rd_14 got err=%b expected 1", er_q[3]); end
    n_cmp++;
    if (er_q[4] !== 1'b0 || rd_q[4] !== 32'h77) begin
      n_bad++; $display("FAIL value_intact got err=%b rdata=%h expected 0/77", er_q[4], rd_q[4]);
    end
    n_cmp++;
    if (rd_q[5] !== 32'h77) begin n_bad++; $display("FAIL alias_addr5 got %h expected 77", rd_q[5]); end
  endtask

  task automatic test_reset_mid();
    wr(32'h8, 32'h1234);
    run_seq();
    @(negedge clk);
    req_v = 1'b1; we_v = 1'b0; addr_v = 32'h8; be_v = 4'h0;
    @(negedge clk);
    req_v = 1'b0; rst = 1'b1;
    #1;
    $display("txn we=0 addr=00000008 reset-abort -> rvalid=%0b", rvalid);
    n_cmp++;
    if (rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_rvalid got %b expected 0", rvalid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (obi_rsp !== 39'h0) begin n_bad++; $display("FAIL rst_mid_rsp got %h expected 0", obi_rsp); end
    rd(32'h8);
    run_seq();
    n_cmp++;
    if (rd_q[0] !== 32'h0) begin n_bad++; $display("FAIL rst_mid_cmp got %h expected 0", rd_q[0]); end
  endtask

  initial begin
    test_reset();
    test_back_to_back_reads();
    test_count_wrap();
    test_oneshot();
    test_value_wrap_collision();
    test_byte_write();
    test_unmapped();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
